// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen
//   Multi-obstacle generator for the 16x16 snake playfield (4-bit coordinates).
//   Holds up to MAX_OBS obstacle cells. A rising edge on spawn_req while obstacle mode is on
//   draws a candidate cell from the random source. A scan FSM then validates it against the
//   border, existing obstacles, the head's 3x3 neighbourhood and every snake body entry.
//   Rejected candidates are retried with fresh randoms, up to MAX_RETRY attempts in total.
//   A combinational per-pixel query reports whether (x,y) is a live obstacle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_reset         game restart pulse, clears the field like rst
//   obstacle_en     obstacle mode flag
//   spawn_req       spawn request level, rising edge requests a spawn
//   randX, randY    random candidate coordinates
//   body            packed snake body, entry i = {x,y} at [i*8 +: 8], entry 0 = head
//   curr_length     number of valid body entries (0 behaves as 1)
//   x, y            pixel query coordinates
//   obstacle        (x,y) is a live obstacle and obstacle_en is high
//   obstacleCount   registered live obstacle count
//   busy            spawn FSM is not idle
//   spawn_fail      one-cycle pulse when a spawn is abandoned
//
// Build option
//   OBSTACLE_REPLACE_EN: when the field is full, new spawns overwrite the oldest slot
//   (round-robin write pointer). Without it, spawns are ignored when full and slots fill
//   lowest-free-first.
module obstacle_field_gen #(
  parameter int MAX_LENGTH = 70,
  parameter int MAX_OBS    = 8,
  parameter int MAX_RETRY  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_reset,
  input  logic                    obstacle_en,
  input  logic                    spawn_req,
  input  logic [3:0]              randX,
  input  logic [3:0]              randY,
  input  logic [MAX_LENGTH*8-1:0] body,
  input  logic [7:0]              curr_length,
  input  logic [3:0]              x,
  input  logic [3:0]              y,
  output logic                    obstacle,
  output logic [3:0]              obstacleCount,
  output logic                    busy,
  output logic                    spawn_fail
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_RETRY  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]         state;
  logic [7:0]         cand;
  logic [7:0]         idx;
  logic [7:0]         tries;
  logic               reject;
  logic               pending;
  logic               spawn_req_q;
  logic [MAX_OBS-1:0] slot_valid;
  logic [7:0]         slot_xy [MAX_OBS];

`ifdef OBSTACLE_REPLACE_EN
  localparam int IW = (MAX_OBS > 1) ? $clog2(MAX_OBS) : 1;
  logic [IW-1:0]      wr_ptr;
`endif

  logic               full;
  logic               can_accept;
  logic               req_edge;
  logic               start_edge;
  logic [7:0]         head;
  logic [7:0]         body_entry;
  logic [7:0]         scan_last;
  logic [4:0]         dx;
  logic [4:0]         dy;
  logic               border_hit;
  logic               head_hit;
  logic               slot_hit;
  logic               body_hit;
  logic               reject_next;
  logic [MAX_OBS-1:0] wr_onehot;
  logic               commit_we;

  assign full     = (obstacleCount == 4'(MAX_OBS));
  assign req_edge = spawn_req & ~spawn_req_q;
  assign busy     = (state != ST_IDLE);

`ifdef OBSTACLE_REPLACE_EN
  assign can_accept = 1'b1;
  assign wr_onehot  = MAX_OBS'(1) << wr_ptr;
`else
  assign can_accept = ~full;
  // Isolates the lowest clear bit of slot_valid: lowest-free-first allocation.
  assign wr_onehot  = ~slot_valid & (slot_valid + MAX_OBS'(1));
`endif

  assign start_edge = req_edge & can_accept;

  // Last body index to scan: a zero length still scans the head, long bodies clamp.
  always_comb begin
    if (curr_length == 8'd0)
      scan_last = 8'd0;
    else if (curr_length > 8'(MAX_LENGTH))
      scan_last = 8'(MAX_LENGTH - 1);
    else
      scan_last = curr_length - 8'd1;
  end

  // One body entry per cycle is compared against the candidate.
  always_comb begin
    body_entry = 8'h00;
    for (int i = 0; i < MAX_LENGTH; i++)
      if (idx == 8'(i))
        body_entry = body[i*8 +: 8];
  end

  assign head = body[7:0];
  assign dx   = {1'b0, cand[7:4]} - {1'b0, head[7:4]};
  assign dy   = {1'b0, cand[3:0]} - {1'b0, head[3:0]};

  // A difference of 5'h1f is -1 in 5-bit two's complement, so {0,+1,-1} is the 3x3 window.
  assign head_hit   = ((dx == 5'd0) || (dx == 5'd1) || (dx == 5'h1f)) &&
                      ((dy == 5'd0) || (dy == 5'd1) || (dy == 5'h1f));
  assign border_hit = (cand[7:4] == 4'd0) || (cand[7:4] == 4'd15) ||
                      (cand[3:0] == 4'd0) || (cand[3:0] == 4'd15);
  assign body_hit   = (body_entry == cand);

  always_comb begin
    slot_hit = 1'b0;
    for (int i = 0; i < MAX_OBS; i++)
      if (slot_valid[i] && (slot_xy[i] == cand))
        slot_hit = 1'b1;
  end

  // The parallel checks only count on the first scan cycle (idx 0).
  assign reject_next = reject | body_hit |
                       ((idx == 8'd0) & (border_hit | head_hit | slot_hit));

  always_comb begin
    obstacle = 1'b0;
    for (int i = 0; i < MAX_OBS; i++)
      if (slot_valid[i] && (slot_xy[i] == {x, y}))
        obstacle = obstacle_en;
  end

  assign commit_we = !rst && !s_reset && obstacle_en && (state == ST_COMMIT);

  // Slot coordinates carry no reset; slot_valid qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OBS; i++)
      if (commit_we && wr_onehot[i])
        slot_xy[i] <= cand;
  end

  // Spawn FSM with a one-deep pending request; dropping obstacle_en aborts quietly.
  always_ff @(posedge clk) begin
    if (rst || s_reset) begin
      state         <= ST_IDLE;
      cand          <= 8'h00;
      idx           <= 8'd0;
      tries         <= 8'd0;
      reject        <= 1'b0;
      pending       <= 1'b0;
      spawn_req_q   <= 1'b0;
      slot_valid    <= '0;
      obstacleCount <= 4'd0;
      spawn_fail    <= 1'b0;
`ifdef OBSTACLE_REPLACE_EN
      wr_ptr        <= '0;
`endif
    end else begin
      spawn_req_q <= spawn_req;
      spawn_fail  <= 1'b0;
      if (!obstacle_en) begin
        state   <= ST_IDLE;
        pending <= 1'b0;
      end else begin
        if (state != ST_IDLE && start_edge)
          pending <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (can_accept && (req_edge || pending)) begin
              state  <= ST_CHECK;
              cand   <= {randX, randY};
              idx    <= 8'd0;
              tries  <= 8'd0;
              reject <= 1'b0;
            end
            pending <= 1'b0;
          end
          ST_CHECK: begin
            reject <= reject_next;
            if (idx >= scan_last)
              state <= reject_next ? ST_RETRY : ST_COMMIT;
            else
              idx <= idx + 8'd1;
          end
          ST_RETRY: begin
            if (tries == 8'(MAX_RETRY - 1)) begin
              spawn_fail <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              cand   <= {randX, randY};
              tries  <= tries + 8'd1;
              idx    <= 8'd0;
              reject <= 1'b0;
              state  <= ST_CHECK;
            end
          end
          ST_COMMIT: begin
            for (int i = 0; i < MAX_OBS; i++)
              if (wr_onehot[i])
                slot_valid[i] <= 1'b1;
            if (!full && (|wr_onehot))
              obstacleCount <= obstacleCount + 4'd1;
`ifdef OBSTACLE_REPLACE_EN
            wr_ptr <= (wr_ptr == IW'(MAX_OBS - 1)) ? '0 : wr_ptr + 1'b1;
`endif
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
